// File: rtl/mode_scheduler_pkg.sv
// Shared types and constants for the mode scheduler: FSM state encoding,
// one-hot mode codes, the per-mode period table and the default tick divider.
package mode_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam logic [3:0] MODE0_OH = 4'b0001;
    localparam logic [3:0] MODE1_OH = 4'b0010;
    localparam logic [3:0] MODE2_OH = 4'b0100;
    localparam logic [3:0] MODE3_OH = 4'b1000;

    localparam logic [3:0] MODE_OH [4] = '{MODE0_OH, MODE1_OH, MODE2_OH, MODE3_OH};

    // Period code applied in AUTO when the table build option is enabled
    localparam logic [3:0] PERIOD_TABLE [4] = '{4'd2, 4'd4, 4'd8, 4'd12};

    // 1 s dwell tick at a 12 MHz system clock
    localparam int unsigned TICK_DIV_DEFAULT = 12000000;

    // Lowest set request bit wins; caller qualifies with |req
    function automatic logic [1:0] first_req(input logic [3:0] req);
        logic [1:0] idx;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mode_scheduler_tick.sv
// tick_gen: free-running prescaler counting 0..TICK_DIV-1, one-cycle tick at wrap.
module tick_gen
    import mode_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the last value
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mode_scheduler.sv
// mode_scheduler: selects one of four LED modes by key request or auto-cycling,
// blanking mode_select for GAP_CYC cycles at every mode change.
// Build option: define MODE_SCHED_PERIOD_TABLE_EN to take the period code from
// PERIOD_TABLE while in AUTO; otherwise period always follows sw_period.
module mode_scheduler
    import mode_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int unsigned DWELL_TICKS = 4,
    parameter int unsigned GAP_CYC     = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_req,
    input  logic       auto_en,
    input  logic [3:0] sw_period,
    output logic [3:0] mode_select,
    output logic [3:0] period,
    output logic       mode_chg,
    output logic [1:0] state
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    state_e        state_q, state_d;
    logic [1:0]    cur_mode_q, cur_mode_d;
    logic [1:0]    target_q, target_d;
    logic [3:0]    mode_sel_q, mode_sel_d;
    logic          mode_chg_q, mode_chg_d;
    logic [3:0]    period_q, period_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;

    logic          tick;
    logic          key_hit;
    logic [1:0]    key_idx;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign key_hit = |key_req;
    assign key_idx = first_req(key_req);

    // Next-state, target/mode selection and counters
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        target_d   = target_q;
        mode_sel_d = mode_sel_q;
        mode_chg_d = 1'b0;
        gap_cnt_d  = '0;
        dwell_d    = '0;

        case (state_q)
            ST_MANUAL: begin
                if (key_hit) begin
                    target_d   = key_idx;
                    mode_sel_d = '0;
                    state_d    = ST_GAP;
                end else if (auto_en) begin
                    state_d = ST_AUTO;
                end
            end
            ST_AUTO: begin
                dwell_d = dwell_q;
                if (key_hit) begin
                    target_d   = key_idx;
                    mode_sel_d = '0;
                    state_d    = ST_GAP;
                    dwell_d    = '0;
                end else if (!auto_en) begin
                    state_d = ST_MANUAL;
                    dwell_d = '0;
                end else if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        target_d   = cur_mode_q + 2'd1;
                        mode_sel_d = '0;
                        state_d    = ST_GAP;
                        dwell_d    = '0;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (key_hit) begin
                    // The retarget cycle is itself gap cycle 0 of the new count
                    target_d  = key_idx;
                    gap_cnt_d = GW'(1);
                end else if (gap_cnt_q >= GAP_LAST) begin
                    cur_mode_d = target_q;
                    mode_sel_d = MODE_OH[target_q];
                    mode_chg_d = 1'b1;
                    state_d    = auto_en ? ST_AUTO : ST_MANUAL;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase

`ifdef MODE_SCHED_PERIOD_TABLE_EN
        if (state_d == ST_AUTO) begin
            period_d = PERIOD_TABLE[cur_mode_d];
        end else begin
            period_d = sw_period;
        end
`else
        period_d = sw_period;
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_MANUAL;
            cur_mode_q <= 2'd0;
            target_q   <= 2'd0;
            mode_sel_q <= MODE0_OH;
            mode_chg_q <= 1'b0;
            period_q   <= '0;
            gap_cnt_q  <= '0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            target_q   <= target_d;
            mode_sel_q <= mode_sel_d;
            mode_chg_q <= mode_chg_d;
            period_q   <= period_d;
            gap_cnt_q  <= gap_cnt_d;
            dwell_q    <= dwell_d;
        end
    end

    assign mode_select = mode_sel_q;
    assign mode_chg    = mode_chg_q;
    assign period      = period_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mode_scheduler.sv
// Directed testbench for mode_scheduler (TICK_DIV=10, DWELL_TICKS=3, GAP_CYC=2).
module tb_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_req;
    logic       auto_en;
    logic [3:0] sw_period;
    logic [3:0] mode_select;
    logic [3:0] period;
    logic       mode_chg;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int pre_m   = 0;

    localparam int S_MANUAL = 0;
    localparam int S_AUTO   = 1;
    localparam int S_GAP    = 2;

    mode_scheduler #(
        .TICK_DIV    (10),
        .DWELL_TICKS (3),
        .GAP_CYC     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_req     (key_req),
        .auto_en     (auto_en),
        .sw_period   (sw_period),
        .mode_select (mode_select),
        .period      (period),
        .mode_chg    (mode_chg),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference prescaler phase: value the DUT prescaler holds after each edge
    always @(posedge clk) begin
        if (rst) pre_m <= 0;
        else     pre_m <= (pre_m == 9) ? 0 : pre_m + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a one-cycle key request; returns with outputs of cycle N+1 visible
    task automatic press(input logic [3:0] k);
        key_req = k;
        step();
        key_req = '0;
    endtask

    initial begin
        int bad;
        int found;

        rst = 1'b1; key_req = '0; auto_en = 1'b0; sw_period = 4'd5;
        step(); step(); step();
        check("rst_mode",   mode_select, 4'b0001);
        check("rst_state",  state, S_MANUAL);
        check("rst_chg",    mode_chg, 1'b0);
        check("rst_period", period, 4'd0);

        rst = 1'b0;
        bad = 0;
        for (int unsigned i = 0; i < 15; i++) begin
            step();
            if (mode_select !== 4'b0001 || state !== 2'd0 || mode_chg !== 1'b0) bad++;
        end
        check("idle_stable", bad, 0);
        check("idle_period", period, 4'd5);

        // Manual request for mode 2
        sw_period = 4'd9;
        press(4'b0100);
        check("k2_n1_mode",   mode_select, 4'b0000);
        check("k2_n1_state",  state, S_GAP);
        check("k2_n1_period", period, 4'd9);
        step();
        check("k2_n2_mode",  mode_select, 4'b0000);
        check("k2_n2_chg",   mode_chg, 1'b0);
        step();
        check("k2_n3_mode",  mode_select, 4'b0100);
        check("k2_n3_chg",   mode_chg, 1'b1);
        check("k2_n3_state", state, S_MANUAL);
        step();
        check("k2_n4_chg",   mode_chg, 1'b0);
        check("k2_n4_mode",  mode_select, 4'b0100);

        // Same mode requested again still blanks and pulses
        press(4'b0100);
        check("same_n1_mode", mode_select, 4'b0000);
        step(); step();
        check("same_n3_mode", mode_select, 4'b0100);
        check("same_n3_chg",  mode_chg, 1'b1);

        // Multiple bits: lowest index wins
        press(4'b1010);
        step(); step();
        check("arb_mode", mode_select, 4'b0010);
        check("arb_chg",  mode_chg, 1'b1);

        // Retarget during GAP
        press(4'b1000);
        check("rt_n1_state", state, S_GAP);
        press(4'b0001);
        check("rt_n2_mode", mode_select, 4'b0000);
        check("rt_n2_chg",  mode_chg, 1'b0);
        step();
        check("rt_n3_mode", mode_select, 4'b0001);
        check("rt_n3_chg",  mode_chg, 1'b1);

        // Go to mode 3, then auto-cycle
        press(4'b1000);
        step(); step();
        check("m3_mode", mode_select, 4'b1000);
        step();

        found = 0;
        for (int unsigned i = 0; i < 20 && found == 0; i++) begin
            if (pre_m == 0) found = 1;
            else step();
        end
        check("align", found, 1);

        auto_en = 1'b1;
        sw_period = 4'd3;
        step();                      // edge E0
        check("auto_state",  state, S_AUTO);
        check("auto_mode",   mode_select, 4'b1000);
        check("auto_chg",    mode_chg, 1'b0);
        check("auto_period", period, 4'd3);
        bad = 0;
        for (int unsigned i = 1; i <= 28; i++) begin
            step();
            if (mode_select !== 4'b1000 || state !== 2'd1 || mode_chg !== 1'b0) bad++;
        end
        check("auto_dwell", bad, 0);
        step();                      // edge E29: third tick
        check("auto_gap1_mode",  mode_select, 4'b0000);
        check("auto_gap1_state", state, S_GAP);
        step();
        check("auto_gap2_mode",  mode_select, 4'b0000);
        step();
        check("auto_wrap_mode",  mode_select, 4'b0001);
        check("auto_wrap_chg",   mode_chg, 1'b1);
        check("auto_wrap_state", state, S_AUTO);

        // Leaving AUTO keeps the mode
        auto_en = 1'b0;
        step();
        check("man_state", state, S_MANUAL);
        check("man_mode",  mode_select, 4'b0001);
        check("man_chg",   mode_chg, 1'b0);

        // Reset mid-GAP discards the pending target
        press(4'b0100);
        check("rg_state", state, S_GAP);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rg_mode",  mode_select, 4'b0001);
        check("rg_state2", state, S_MANUAL);
        bad = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            step();
            if (mode_select !== 4'b0001 || mode_chg !== 1'b0) bad++;
        end
        check("rg_after", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
